// File: rtl/axil_regbank.sv
// AXI4-Lite slave register bank; RO_MASK registers read back status_in instead of storage.
// Define AXIL_REGBANK_WSTRB_EN to honour per-byte write strobes (default: full-word writes).
module axil_regbank #(
    parameter int unsigned         C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned         NUM_REGS           = 4,
    parameter logic [NUM_REGS-1:0] RO_MASK            = '0,
    localparam int unsigned        DW                 = C_S_AXI_DATA_WIDTH,
    localparam int unsigned        SW                 = DW / 8,
    localparam int unsigned        ADDR_LSB           = $clog2(DW / 8),
    localparam int unsigned        IDX_W              = $clog2(NUM_REGS) + 1,
    localparam int unsigned        C_S_AXI_ADDR_WIDTH = ADDR_LSB + IDX_W
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [DW-1:0]                 S_AXI_WDATA,
    input  logic [SW-1:0]                 S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [DW-1:0]                 S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic [NUM_REGS*DW-1:0]        reg_out,
    input  logic [NUM_REGS*DW-1:0]        status_in,
    output logic [NUM_REGS-1:0]           wr_pulse
);

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rstate_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    wstate_t             wstate;
    rstate_t             rstate;
    logic [DW-1:0]       regs [NUM_REGS];
    logic [IDX_W-1:0]    widx;
    logic [IDX_W-1:0]    ridx;
    logic [NUM_REGS-1:0] whit;
    logic [NUM_REGS-1:0] rhit;
    logic [DW-1:0]       rword;
    logic                unused_bits;

    assign widx = S_AXI_AWADDR[ADDR_LSB +: IDX_W];
    assign ridx = S_AXI_ARADDR[ADDR_LSB +: IDX_W];

    // One-hot address decode; an empty hit vector means an error response.
    always_comb begin
        whit  = '0;
        rhit  = '0;
        rword = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            whit[i] = (widx == IDX_W'(i)) && !RO_MASK[i];
            rhit[i] = (ridx == IDX_W'(i));
            if (rhit[i]) begin
                rword = RO_MASK[i] ? status_in[i*DW +: DW] : regs[i];
            end
        end
    end

    // Write channel FSM and register storage.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wstate        <= W_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            wr_pulse      <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (S_AXI_AWVALID && S_AXI_WVALID) begin
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b1;
                        wstate        <= W_ACK;
                    end
                end
                W_ACK: begin
                    S_AXI_AWREADY <= 1'b0;
                    S_AXI_WREADY  <= 1'b0;
                    S_AXI_BVALID  <= 1'b1;
                    S_AXI_BRESP   <= (|whit) ? RESP_OKAY : RESP_SLVERR;
                    wr_pulse      <= whit;
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (whit[i]) begin
`ifdef AXIL_REGBANK_WSTRB_EN
                            for (int b = 0; b < SW; b++) begin
                                if (S_AXI_WSTRB[b]) begin
                                    regs[i][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
                                end
                            end
`else
                            regs[i] <= S_AXI_WDATA;
`endif
                        end
                    end
                    wstate <= W_RESP;
                end
                W_RESP: begin
                    wr_pulse <= '0;
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID <= 1'b0;
                        wstate       <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Read channel FSM; data is captured on the edge that leaves R_ACK.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rstate        <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RRESP   <= RESP_OKAY;
            S_AXI_RDATA   <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (S_AXI_ARVALID) begin
                        S_AXI_ARREADY <= 1'b1;
                        rstate        <= R_ACK;
                    end
                end
                R_ACK: begin
                    S_AXI_ARREADY <= 1'b0;
                    S_AXI_RVALID  <= 1'b1;
                    S_AXI_RDATA   <= rword;
                    S_AXI_RRESP   <= (|rhit) ? RESP_OKAY : RESP_SLVERR;
                    rstate        <= R_DATA;
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID <= 1'b0;
                        rstate       <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        assign reg_out[i*DW +: DW] = RO_MASK[i] ? '0 : regs[i];
    end

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB, status_in,
                           S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

endmodule

// File: tb/tb_axil_regbank.sv
// Directed bench for axil_regbank: two instances (RO_MASK=0 and RO_MASK=4'b0100) share one master.
module tb_axil_regbank;

    localparam int unsigned DW = 32;
    localparam int unsigned NR = 4;
    localparam int unsigned AW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [AW-1:0]    awaddr, araddr;
    logic             awvalid, wvalid, bready, arvalid, rready;
    logic [DW-1:0]    wdata;
    logic [3:0]       wstrb;
    logic [NR*DW-1:0] status;

    logic a_awready, a_wready, a_bvalid, a_arready, a_rvalid;
    logic b_awready, b_wready, b_bvalid, b_arready, b_rvalid;
    logic [1:0] a_bresp, a_rresp, b_bresp, b_rresp;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [NR*DW-1:0] a_reg_out, b_reg_out;
    logic [NR-1:0] a_wr_pulse, b_wr_pulse;

    int total = 0;
    int bad   = 0;

    // results captured by the bus tasks
    logic        w_ok, r_ok;
    logic [1:0]  wa_resp, wb_resp, ra_resp, rb_resp;
    logic [3:0]  wa_pulse, wb_pulse;
    logic [9:0]  w_tail;
    logic [31:0] ra_data, rb_data;

    axil_regbank #(.C_S_AXI_DATA_WIDTH(32), .NUM_REGS(4), .RO_MASK(4'b0000)) dut_a (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(a_awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(a_wready),
        .S_AXI_BRESP(a_bresp), .S_AXI_BVALID(a_bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(a_arready),
        .S_AXI_RDATA(a_rdata), .S_AXI_RRESP(a_rresp), .S_AXI_RVALID(a_rvalid), .S_AXI_RREADY(rready),
        .reg_out(a_reg_out), .status_in(status), .wr_pulse(a_wr_pulse)
    );

    axil_regbank #(.C_S_AXI_DATA_WIDTH(32), .NUM_REGS(4), .RO_MASK(4'b0100)) dut_b (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(b_awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(b_wready),
        .S_AXI_BRESP(b_bresp), .S_AXI_BVALID(b_bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(b_arready),
        .S_AXI_RDATA(b_rdata), .S_AXI_RRESP(b_rresp), .S_AXI_RVALID(b_rvalid), .S_AXI_RREADY(rready),
        .reg_out(b_reg_out), .status_in(status), .wr_pulse(b_wr_pulse)
    );

    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb);
        w_ok = 1'b0;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_awready) begin w_ok = 1'b1; break; end
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        if (w_ok) begin
            w_ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (a_bvalid) begin w_ok = 1'b1; break; end
                @(negedge clk);
            end
            wa_resp = a_bresp; wb_resp = b_bresp;
            wa_pulse = a_wr_pulse; wb_pulse = b_wr_pulse;
            bready = 1'b1;
            @(negedge clk);
            bready = 1'b0;
            w_tail = {a_bvalid, b_bvalid, a_wr_pulse, b_wr_pulse};
        end
    endtask

    task automatic axi_read(input logic [AW-1:0] addr);
        r_ok = 1'b0;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_arready) begin r_ok = 1'b1; break; end
        end
        @(negedge clk);
        arvalid = 1'b0;
        if (r_ok) begin
            r_ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (a_rvalid) begin r_ok = 1'b1; break; end
                @(negedge clk);
            end
            ra_data = a_rdata; rb_data = b_rdata; ra_resp = a_rresp; rb_resp = b_rresp;
            rready = 1'b1;
            @(negedge clk);
            rready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({a_awready, a_wready, a_bvalid, a_arready, a_rvalid, b_awready, b_wready, b_bvalid, b_arready, b_rvalid} !== 10'b0) begin
            bad++; $display("FAIL reset_handshake: got %b want 0", {a_awready, a_wready, a_bvalid, a_arready, a_rvalid, b_awready, b_wready, b_bvalid, b_arready, b_rvalid});
        end
        total++;
        if ({a_bresp, a_rresp, b_bresp, b_rresp} !== 8'b0) begin
            bad++; $display("FAIL reset_resp: got %b want 0", {a_bresp, a_rresp, b_bresp, b_rresp});
        end
        total++;
        if ({a_rdata, b_rdata} !== 64'b0) begin
            bad++; $display("FAIL reset_rdata: got %h want 0", {a_rdata, b_rdata});
        end
        total++;
        if ({a_reg_out, b_reg_out} !== 256'b0) begin
            bad++; $display("FAIL reset_reg_out: got %h want 0", {a_reg_out, b_reg_out});
        end
        total++;
        if ({a_wr_pulse, b_wr_pulse} !== 8'b0) begin
            bad++; $display("FAIL reset_wr_pulse: got %b want 0", {a_wr_pulse, b_wr_pulse});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [1:0]  eb;
        logic [3:0]  pa, pb;
        logic [31:0] ea, ebd;
        for (int i = 0; i < 4; i++) begin
            axi_write(AW'(i * 4), 32'(i + 1), 4'hF);
            eb = (i == 2) ? 2'b10 : 2'b00;
            pa = 4'(1 << i);
            pb = (i == 2) ? 4'b0 : 4'(1 << i);
            total++;
            if (w_ok !== 1'b1) begin bad++; $display("FAIL basic_wr_timeout[%0d]: got %b want 1", i, w_ok); end
            total++;
            if ({wa_resp, wb_resp} !== {2'b00, eb}) begin
                bad++; $display("FAIL basic_bresp[%0d]: got %b want %b", i, {wa_resp, wb_resp}, {2'b00, eb});
            end
            total++;
            if ({wa_pulse, wb_pulse} !== {pa, pb}) begin
                bad++; $display("FAIL basic_wr_pulse[%0d]: got %b want %b", i, {wa_pulse, wb_pulse}, {pa, pb});
            end
            total++;
            if (w_tail !== 10'b0) begin
                bad++; $display("FAIL basic_tail[%0d]: got %b want 0", i, w_tail);
            end
        end
        total++;
        if (a_reg_out !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
            bad++; $display("FAIL basic_reg_out_a: got %h want %h", a_reg_out, {32'd4, 32'd3, 32'd2, 32'd1});
        end
        total++;
        if (b_reg_out !== {32'd4, 32'd0, 32'd2, 32'd1}) begin
            bad++; $display("FAIL basic_reg_out_b: got %h want %h", b_reg_out, {32'd4, 32'd0, 32'd2, 32'd1});
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(AW'(i * 4));
            ea  = 32'(i + 1);
            ebd = (i == 2) ? 32'hDEADBEEF : 32'(i + 1);
            total++;
            if (r_ok !== 1'b1) begin bad++; $display("FAIL basic_rd_timeout[%0d]: got %b want 1", i, r_ok); end
            total++;
            if ({ra_data, rb_data} !== {ea, ebd}) begin
                bad++; $display("FAIL basic_rdata[%0d]: got %h want %h", i, {ra_data, rb_data}, {ea, ebd});
            end
            total++;
            if ({ra_resp, rb_resp} !== 4'b0) begin
                bad++; $display("FAIL basic_rresp[%0d]: got %b want 0", i, {ra_resp, rb_resp});
            end
        end
    endtask

    task automatic test_out_of_range();
        axi_write(5'h10, 32'hFFFF_FFFF, 4'hF);
        total++;
        if ({w_ok, wa_resp, wb_resp} !== 5'b1_10_10) begin
            bad++; $display("FAIL oor_bresp: got %b want 11010", {w_ok, wa_resp, wb_resp});
        end
        total++;
        if ({wa_pulse, wb_pulse} !== 8'b0) begin
            bad++; $display("FAIL oor_wr_pulse: got %b want 0", {wa_pulse, wb_pulse});
        end
        total++;
        if ({a_reg_out, b_reg_out} !== {32'd4, 32'd3, 32'd2, 32'd1, 32'd4, 32'd0, 32'd2, 32'd1}) begin
            bad++; $display("FAIL oor_reg_out: got %h want unchanged", {a_reg_out, b_reg_out});
        end
        axi_read(5'h10);
        total++;
        if ({r_ok, ra_data, rb_data, ra_resp, rb_resp} !== {1'b1, 64'b0, 4'b1010}) begin
            bad++; $display("FAIL oor_read10: got %h want %h", {r_ok, ra_data, rb_data, ra_resp, rb_resp}, {1'b1, 64'b0, 4'b1010});
        end
        axi_read(5'h1C);
        total++;
        if ({r_ok, ra_data, rb_data, ra_resp, rb_resp} !== {1'b1, 64'b0, 4'b1010}) begin
            bad++; $display("FAIL oor_read1c: got %h want %h", {r_ok, ra_data, rb_data, ra_resp, rb_resp}, {1'b1, 64'b0, 4'b1010});
        end
        axi_read(5'h06);
        total++;
        if ({r_ok, ra_data, rb_data, ra_resp, rb_resp} !== {1'b1, 32'd2, 32'd2, 4'b0000}) begin
            bad++; $display("FAIL low_addr_bits: got %h want %h", {r_ok, ra_data, rb_data, ra_resp, rb_resp}, {1'b1, 32'd2, 32'd2, 4'b0000});
        end
    endtask

    task automatic test_ro();
        axi_write(5'h08, 32'h55, 4'hF);
        total++;
        if ({w_ok, wa_resp, wb_resp, wa_pulse, wb_pulse} !== {1'b1, 2'b00, 2'b10, 4'b0100, 4'b0000}) begin
            bad++; $display("FAIL ro_write: got %b want %b", {w_ok, wa_resp, wb_resp, wa_pulse, wb_pulse}, {1'b1, 2'b00, 2'b10, 4'b0100, 4'b0000});
        end
        total++;
        if ({a_reg_out[64 +: 32], b_reg_out[64 +: 32]} !== {32'h55, 32'h0}) begin
            bad++; $display("FAIL ro_reg_out: got %h want %h", {a_reg_out[64 +: 32], b_reg_out[64 +: 32]}, {32'h55, 32'h0});
        end
        axi_read(5'h08);
        total++;
        if ({r_ok, ra_data, rb_data, ra_resp, rb_resp} !== {1'b1, 32'h55, 32'hDEADBEEF, 4'b0000}) begin
            bad++; $display("FAIL ro_read: got %h want %h", {r_ok, ra_data, rb_data, ra_resp, rb_resp}, {1'b1, 32'h55, 32'hDEADBEEF, 4'b0000});
        end
        status[64 +: 32] = 32'h1234_5678;
        axi_read(5'h08);
        total++;
        if ({r_ok, rb_data, rb_resp} !== {1'b1, 32'h1234_5678, 2'b00}) begin
            bad++; $display("FAIL ro_status_track: got %h want %h", {r_ok, rb_data, rb_resp}, {1'b1, 32'h1234_5678, 2'b00});
        end
    endtask

    task automatic test_wstrb();
        logic [31:0] e1, e2;
`ifdef AXIL_REGBANK_WSTRB_EN
        e1 = 32'h11BB33DD;
        e2 = 32'h11BB33DD;
`else
        e1 = 32'hAABBCCDD;
        e2 = 32'h01020304;
`endif
        axi_write(5'h00, 32'h1122_3344, 4'hF);
        axi_write(5'h00, 32'hAABB_CCDD, 4'b0101);
        total++;
        if ({w_ok, wa_resp, wb_resp, wa_pulse, wb_pulse} !== {1'b1, 4'b0000, 4'b0001, 4'b0001}) begin
            bad++; $display("FAIL wstrb_resp: got %b want %b", {w_ok, wa_resp, wb_resp, wa_pulse, wb_pulse}, {1'b1, 4'b0000, 4'b0001, 4'b0001});
        end
        total++;
        if ({a_reg_out[31:0], b_reg_out[31:0]} !== {e1, e1}) begin
            bad++; $display("FAIL wstrb_partial: got %h want %h", {a_reg_out[31:0], b_reg_out[31:0]}, {e1, e1});
        end
        axi_write(5'h00, 32'h0102_0304, 4'b0000);
        total++;
        if ({w_ok, wa_resp, wb_resp, wa_pulse, wb_pulse} !== {1'b1, 4'b0000, 4'b0001, 4'b0001}) begin
            bad++; $display("FAIL wstrb_zero_resp: got %b want %b", {w_ok, wa_resp, wb_resp, wa_pulse, wb_pulse}, {1'b1, 4'b0000, 4'b0001, 4'b0001});
        end
        total++;
        if ({a_reg_out[31:0], b_reg_out[31:0]} !== {e2, e2}) begin
            bad++; $display("FAIL wstrb_zero_data: got %h want %h", {a_reg_out[31:0], b_reg_out[31:0]}, {e2, e2});
        end
    endtask

    task automatic test_stall();
        logic seen;
        @(negedge clk);
        awaddr = 5'h04; wdata = 32'hCAFE_0001; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({a_awready, a_wready, b_awready, b_wready} !== 4'b0) begin
                bad++; $display("FAIL stall_aw_only[%0d]: got %b want 0", i, {a_awready, a_wready, b_awready, b_wready});
            end
        end
        wvalid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_awready) begin seen = 1'b1; break; end
        end
        total++;
        if ({seen, a_wready, b_awready, b_wready} !== 4'b1111) begin
            bad++; $display("FAIL stall_accept: got %b want 1111", {seen, a_wready, b_awready, b_wready});
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({a_bvalid, b_bvalid, a_bresp, b_bresp} !== 6'b11_00_00) begin
                bad++; $display("FAIL stall_bhold[%0d]: got %b want 110000", i, {a_bvalid, b_bvalid, a_bresp, b_bresp});
            end
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        total++;
        if ({a_bvalid, b_bvalid, a_reg_out[32 +: 32], b_reg_out[32 +: 32]} !== {2'b00, 32'hCAFE_0001, 32'hCAFE_0001}) begin
            bad++; $display("FAIL stall_done: got %h want %h", {a_bvalid, b_bvalid, a_reg_out[32 +: 32], b_reg_out[32 +: 32]}, {2'b00, 32'hCAFE_0001, 32'hCAFE_0001});
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        @(negedge clk);
        awaddr = 5'h0C; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_bvalid) begin seen = 1'b1; break; end
            if (a_awready) begin awvalid = 1'b0; wvalid = 1'b0; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        total++;
        if ({seen, b_bvalid} !== 2'b11) begin
            bad++; $display("FAIL rstmid_bvalid_before: got %b want 11", {seen, b_bvalid});
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({a_bvalid, b_bvalid, a_wr_pulse, b_wr_pulse} !== 10'b0) begin
            bad++; $display("FAIL rstmid_bvalid_after: got %b want 0", {a_bvalid, b_bvalid, a_wr_pulse, b_wr_pulse});
        end
        total++;
        if ({a_reg_out, b_reg_out} !== 256'b0) begin
            bad++; $display("FAIL rstmid_reg_out: got %h want 0", {a_reg_out, b_reg_out});
        end
        axi_write(5'h04, 32'h3C, 4'hF);
        total++;
        if ({w_ok, wa_resp, wb_resp, wa_pulse, wb_pulse} !== {1'b1, 4'b0000, 4'b0010, 4'b0010}) begin
            bad++; $display("FAIL rstmid_rewrite: got %b want %b", {w_ok, wa_resp, wb_resp, wa_pulse, wb_pulse}, {1'b1, 4'b0000, 4'b0010, 4'b0010});
        end
        total++;
        if (a_reg_out !== {32'h0, 32'h0, 32'h3C, 32'h0}) begin
            bad++; $display("FAIL rstmid_reg_after: got %h want %h", a_reg_out, {32'h0, 32'h0, 32'h3C, 32'h0});
        end
    endtask

    task automatic test_back_to_back();
        logic seen;
        @(negedge clk);
        awaddr = 5'h04; wdata = 32'h99; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 5'h04; arvalid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_awready) begin seen = 1'b1; break; end
        end
        total++;
        if ({seen, a_arready, b_arready} !== 3'b111) begin
            bad++; $display("FAIL rw_same_accept: got %b want 111", {seen, a_arready, b_arready});
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        total++;
        if ({a_bvalid, a_rvalid, a_rdata, b_rdata} !== {2'b11, 32'h3C, 32'h3C}) begin
            bad++; $display("FAIL rw_same_prewrite: got %h want %h", {a_bvalid, a_rvalid, a_rdata, b_rdata}, {2'b11, 32'h3C, 32'h3C});
        end
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        total++;
        if ({a_bvalid, a_rvalid, a_reg_out[32 +: 32]} !== {2'b00, 32'h99}) begin
            bad++; $display("FAIL rw_same_after: got %h want %h", {a_bvalid, a_rvalid, a_reg_out[32 +: 32]}, {2'b00, 32'h99});
        end
        axi_read(5'h04);
        total++;
        if ({r_ok, ra_data, rb_data} !== {1'b1, 32'h99, 32'h99}) begin
            bad++; $display("FAIL rw_same_readback: got %h want %h", {r_ok, ra_data, rb_data}, {1'b1, 32'h99, 32'h99});
        end
    endtask

    initial begin
        awaddr = '0; araddr = '0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arvalid = 1'b0; rready = 1'b0; wdata = '0; wstrb = '0;
        status = {32'hA5A5_0003, 32'hDEAD_BEEF, 32'hA5A5_0001, 32'hA5A5_0000};
        w_ok = 1'b0; r_ok = 1'b0;
        test_reset();
        test_basic();
        test_out_of_range();
        test_ro();
        test_wstrb();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/axil_regbank.md
AXIL_REGBANK -- requirements
Module: axil_regbank

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, 32, AXI4-Lite data width; legal values 32 or 64.
REQ-002 Parameter NUM_REGS, 4, number of registers; legal range 2..256.
REQ-003 Parameter RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only, sourced from status_in.
REQ-004 Localparam ADDR_LSB = clog2(C_S_AXI_DATA_WIDTH/8); localparam C_S_AXI_ADDR_WIDTH = ADDR_LSB + clog2(NUM_REGS) + 1.
REQ-005 ACLK  in  1  single clock; all logic on rising edge.
REQ-006 ARESET  in  1  asynchronous, active-high reset.
REQ-007 S_AXI_AWADDR/AWPROT/AWVALID in, S_AXI_AWREADY out  C_S_AXI_ADDR_WIDTH/3/1/1  write address channel; AWPROT ignored.
REQ-008 S_AXI_WDATA/WSTRB/WVALID in, S_AXI_WREADY out  DW/DW/8/1/1  write data channel.
REQ-009 S_AXI_BRESP/BVALID out, S_AXI_BREADY in  2/1/1  write response channel.
REQ-010 S_AXI_ARADDR/ARPROT/ARVALID in, S_AXI_ARREADY out  C_S_AXI_ADDR_WIDTH/3/1/1  read address channel; ARPROT ignored.
REQ-011 S_AXI_RDATA/RRESP/RVALID out, S_AXI_RREADY in  DW/2/1/1  read data channel.
REQ-012 reg_out  out  NUM_REGS*DW  flat register contents; register i at bits [i*DW +: DW].
REQ-013 status_in  in  NUM_REGS*DW  flat status values; slice i read when RO_MASK[i]=1.
REQ-014 wr_pulse  out  NUM_REGS  one-cycle strobe per register on a successful write.

Function
REQ-015 Write FSM states W_IDLE, W_ACK, W_RESP; read FSM states R_IDLE, R_ACK, R_DATA; both FSMs run independently.
REQ-016 W_IDLE -> W_ACK only when AWVALID and WVALID are both high in the same cycle; neither channel is accepted alone.
REQ-017 In W_ACK, AWREADY and WREADY are high for exactly one cycle; the target register updates on that edge; next state W_RESP.
REQ-018 In W_RESP, BVALID is high and wr_pulse[idx] is high for the first W_RESP cycle only; BVALID holds until BREADY, then -> W_IDLE.
REQ-019 R_IDLE -> R_ACK on ARVALID; ARREADY is high for one cycle in R_ACK; RDATA/RRESP are registered at that edge; -> R_DATA.
REQ-020 In R_DATA, RVALID is high and RDATA/RRESP are stable until RREADY, then -> R_IDLE.
REQ-021 Register index = ADDR[ADDR_LSB +: clog2(NUM_REGS)+1]; ADDR bits below ADDR_LSB are ignored.
REQ-022 Index >= NUM_REGS: a write leaves all state unchanged with BRESP=2'b10; a read returns RDATA=0 with RRESP=2'b10.
REQ-023 Write to a RO_MASK register: no update, no wr_pulse, BRESP=2'b10.
REQ-024 All other accesses return RESP=2'b00.
REQ-025 A read of register i where RO_MASK[i]=1 returns the status_in slice sampled on the R_ACK edge.
REQ-026 Read and write to the same register completing on the same edge: the read returns the pre-write value.
REQ-027 reg_out slices for RO_MASK registers are driven 0.

Reset
REQ-028 While ARESET is high, all registers are 0, both FSMs are in IDLE, all READY/VALID outputs are 0, RESP outputs are 0, RDATA is 0 and wr_pulse is 0.
REQ-029 Reset asserted mid-transaction aborts the transaction; no pending BVALID or RVALID survives reset.

Configuration
REQ-030 With macro AXIL_REGBANK_WSTRB_EN defined, byte lane b of the register is written only when WSTRB[b]=1; lanes with WSTRB[b]=0 keep their value; WSTRB=0 still gives BRESP=OKAY and a wr_pulse.
REQ-031 Without AXIL_REGBANK_WSTRB_EN, WSTRB is ignored and every write replaces the full word.

Verification
REQ-032 DW=32, NUM_REGS=4: write 1,2,3,4 to addresses 0x0,0x4,0x8,0xC, then read back -> RDATA 1,2,3,4, all RESP=OKAY, one wr_pulse per write.
REQ-033 Write to 0x10 with NUM_REGS=4 -> BRESP=2'b10 and reg_out unchanged; read 0x10 -> RDATA=0, RRESP=2'b10.
REQ-034 RO_MASK=4'b0100, status_in slice 2=0xDEADBEEF: write 0x55 to 0x8 -> BRESP=2'b10; read 0x8 -> 0xDEADBEEF.
REQ-035 WSTRB_EN defined: reg0=0x11223344, write 0xAABBCCDD with WSTRB=4'b0101 -> reg0=0x11BB33DD; with the macro undefined -> reg0=0xAABBCCDD.
REQ-036 AWVALID high 5 cycles before WVALID -> AWREADY stays 0 until both are high; BREADY held low 3 cycles -> BVALID held 3 cycles, BRESP stable.
REQ-037 ARESET pulsed while BVALID is high -> BVALID=0 and reg_out=0 on the next cycle; a subsequent write completes normally.
